// File: rtl/box_frame_sched.sv
// Bounding-box frame scheduler: collects a set of boxes into staging slots and
// commits them atomically to the overlay outputs on the next vertical blank.
module box_frame_sched #(
  parameter int unsigned NUM_BOX      = 4,
  parameter int unsigned COORD_W      = 11,
  parameter int unsigned STALE_FRAMES = 30
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_start,
  input  logic               box_valid,
  output logic               box_ready,
  input  logic [COORD_W-1:0] box_left,
  input  logic [COORD_W-1:0] box_right,
  input  logic [COORD_W-1:0] box_top,
  input  logic [COORD_W-1:0] box_bottom,
  input  logic               box_last,
  output logic [COORD_W-1:0] line_left,
  output logic [COORD_W-1:0] line_right,
  output logic [COORD_W-1:0] line_top,
  output logic [COORD_W-1:0] line_bottom,
  output logic [COORD_W-1:0] line_left2,
  output logic [COORD_W-1:0] line_right2,
  output logic [COORD_W-1:0] line_top2,
  output logic [COORD_W-1:0] line_bottom2,
  output logic [COORD_W-1:0] line_left3,
  output logic [COORD_W-1:0] line_right3,
  output logic [COORD_W-1:0] line_top3,
  output logic [COORD_W-1:0] line_bottom3,
  output logic [COORD_W-1:0] line_left4,
  output logic [COORD_W-1:0] line_right4,
  output logic [COORD_W-1:0] line_top4,
  output logic [COORD_W-1:0] line_bottom4,
  output logic               ena,
  output logic [2:0]         box_count,
  output logic               overflow_err
);

  // The output port list fixes four physical slots; NUM_BOX limits how many are used.
  localparam int unsigned NumSlot  = 4;
  localparam int unsigned NumBoxI  = (NUM_BOX > NumSlot) ? NumSlot : NUM_BOX;
  localparam logic [2:0]  NumBoxC  = 3'(NumBoxI);
  localparam logic [7:0]  StaleC   = 8'(STALE_FRAMES);

  typedef enum logic [0:0] {StCollect, StPending} state_e;

  state_e             state_q, state_d;
  logic [2:0]         stage_cnt_q, stage_cnt_d;
  logic [7:0]         stale_q, stale_d;
  logic               ovf_q, ovf_d;
  logic [2:0]         cnt_q, cnt_d;
  logic               ena_q, ena_d;

  logic [COORD_W-1:0] stg_l_q [NumSlot];
  logic [COORD_W-1:0] stg_r_q [NumSlot];
  logic [COORD_W-1:0] stg_t_q [NumSlot];
  logic [COORD_W-1:0] stg_b_q [NumSlot];
  logic [COORD_W-1:0] stg_l_d [NumSlot];
  logic [COORD_W-1:0] stg_r_d [NumSlot];
  logic [COORD_W-1:0] stg_t_d [NumSlot];
  logic [COORD_W-1:0] stg_b_d [NumSlot];
  logic [COORD_W-1:0] act_l_q [NumSlot];
  logic [COORD_W-1:0] act_r_q [NumSlot];
  logic [COORD_W-1:0] act_t_q [NumSlot];
  logic [COORD_W-1:0] act_b_q [NumSlot];
  logic [COORD_W-1:0] act_l_d [NumSlot];
  logic [COORD_W-1:0] act_r_d [NumSlot];
  logic [COORD_W-1:0] act_t_d [NumSlot];
  logic [COORD_W-1:0] act_b_d [NumSlot];

  logic       accept;
  logic       malformed;
  logic       commit;
  logic [7:0] stale_inc;

  assign box_ready = rst_n & (state_q == StCollect);
  assign accept    = box_valid & box_ready;
  assign malformed = (box_left >= box_right) | (box_top >= box_bottom);
  assign commit    = frame_start & (state_q == StPending);
  assign stale_inc = (stale_q >= StaleC) ? StaleC : stale_q + 8'd1;

  always_comb begin
    state_d     = state_q;
    stage_cnt_d = stage_cnt_q;
    stale_d     = stale_q;
    ovf_d       = ovf_q;
    cnt_d       = cnt_q;
    ena_d       = ena_q;
    stg_l_d     = stg_l_q;
    stg_r_d     = stg_r_q;
    stg_t_d     = stg_t_q;
    stg_b_d     = stg_b_q;
    act_l_d     = act_l_q;
    act_r_d     = act_r_q;
    act_t_d     = act_t_q;
    act_b_d     = act_b_q;

    if (commit) begin
      for (int unsigned i = 0; i < NumSlot; i++) begin
        if (3'(i) < stage_cnt_q) begin
          act_l_d[i] = stg_l_q[i];
          act_r_d[i] = stg_r_q[i];
          act_t_d[i] = stg_t_q[i];
          act_b_d[i] = stg_b_q[i];
        end else begin
          act_l_d[i] = '0;
          act_r_d[i] = '0;
          act_t_d[i] = '0;
          act_b_d[i] = '0;
        end
      end
      cnt_d       = stage_cnt_q;
      ena_d       = (stage_cnt_q != 3'd0);
      stage_cnt_d = 3'd0;
      ovf_d       = 1'b0;
      stale_d     = 8'd0;
      state_d     = StCollect;
    end else if (frame_start) begin
      stale_d = stale_inc;
      // Detector has gone quiet: blank the overlay but keep any partial staging set.
      if (stale_inc == StaleC) begin
        for (int unsigned i = 0; i < NumSlot; i++) begin
          act_l_d[i] = '0;
          act_r_d[i] = '0;
          act_t_d[i] = '0;
          act_b_d[i] = '0;
        end
        cnt_d = 3'd0;
        ena_d = 1'b0;
      end
    end

    if (accept) begin
      if (!malformed) begin
        if (stage_cnt_q < NumBoxC) begin
          for (int unsigned i = 0; i < NumSlot; i++) begin
            if (stage_cnt_q == 3'(i)) begin
              stg_l_d[i] = box_left;
              stg_r_d[i] = box_right;
              stg_t_d[i] = box_top;
              stg_b_d[i] = box_bottom;
            end
          end
          stage_cnt_d = stage_cnt_q + 3'd1;
        end else begin
          ovf_d = 1'b1;
        end
      end
      if (box_last) begin
        state_d = StPending;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StCollect;
      stage_cnt_q <= 3'd0;
      stale_q     <= 8'd0;
      ovf_q       <= 1'b0;
      cnt_q       <= 3'd0;
      ena_q       <= 1'b0;
      for (int unsigned i = 0; i < NumSlot; i++) begin
        stg_l_q[i] <= '0;
        stg_r_q[i] <= '0;
        stg_t_q[i] <= '0;
        stg_b_q[i] <= '0;
        act_l_q[i] <= '0;
        act_r_q[i] <= '0;
        act_t_q[i] <= '0;
        act_b_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      stage_cnt_q <= stage_cnt_d;
      stale_q     <= stale_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
      ena_q       <= ena_d;
      stg_l_q     <= stg_l_d;
      stg_r_q     <= stg_r_d;
      stg_t_q     <= stg_t_d;
      stg_b_q     <= stg_b_d;
      act_l_q     <= act_l_d;
      act_r_q     <= act_r_d;
      act_t_q     <= act_t_d;
      act_b_q     <= act_b_d;
    end
  end

  assign line_left    = act_l_q[0];
  assign line_right   = act_r_q[0];
  assign line_top     = act_t_q[0];
  assign line_bottom  = act_b_q[0];
  assign line_left2   = act_l_q[1];
  assign line_right2  = act_r_q[1];
  assign line_top2    = act_t_q[1];
  assign line_bottom2 = act_b_q[1];
  assign line_left3   = act_l_q[2];
  assign line_right3  = act_r_q[2];
  assign line_top3    = act_t_q[2];
  assign line_bottom3 = act_b_q[2];
  assign line_left4   = act_l_q[3];
  assign line_right4  = act_r_q[3];
  assign line_top4    = act_t_q[3];
  assign line_bottom4 = act_b_q[3];
  assign ena          = ena_q;
  assign box_count    = cnt_q;
  assign overflow_err = ovf_q;

endmodule

// File: doc/box_frame_sched.md
BOX_FRAME_SCHED -- requirements
Module: box_frame_sched

Interface
REQ-001 SHALL have parameter NUM_BOX, default 4: number of bounding-box slots.
REQ-002 SHALL have parameter COORD_W, default 11: coordinate width in bits.
REQ-003 SHALL have parameter STALE_FRAMES, default 30: frames without a commit before the overlay is cleared; legal range 1-255.
REQ-004 SHALL have port clk, input, 1 bit: single system clock; all logic is on the rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port frame_start, input, 1 bit: one-cycle pulse at the start of vertical blank.
REQ-007 SHALL have port box_valid, input, 1 bit: a candidate box is presented.
REQ-008 SHALL have port box_ready, output, 1 bit: the block can accept a box this cycle.
REQ-009 SHALL have ports box_left, box_right, box_top and box_bottom, input, COORD_W bits each: candidate box edges.
REQ-010 SHALL have port box_last, input, 1 bit: the presented box closes the current set.
REQ-011 SHALL have ports line_left, line_right, line_top and line_bottom, and the same four with suffixes 2, 3 and 4, output, COORD_W bits each: active box edges per slot.
REQ-012 SHALL have port ena, output, 1 bit: overlay enable for the VGA overlay stage.
REQ-013 SHALL have port box_count, output, 3 bits: number of active boxes.
REQ-014 SHALL have port overflow_err, output, 1 bit: sticky flag, set when an extra box is dropped.

Function
REQ-015 SHALL accept a transfer only on a cycle where box_valid and box_ready are both 1.
REQ-016 SHALL use states COLLECT and PENDING, with COLLECT as the reset state.
REQ-017 SHALL drive box_ready=1 in COLLECT and box_ready=0 in PENDING.
REQ-018 SHALL treat an accepted box with left>=right or top>=bottom as malformed: the box is dropped, no slot is consumed, and box_last is still honoured.
REQ-019 SHALL write each well-formed accepted box into staging slot stage_cnt and increment stage_cnt while stage_cnt<NUM_BOX.
REQ-020 SHALL drop a well-formed box when stage_cnt==NUM_BOX and set overflow_err.
REQ-021 SHALL, on an accepted beat with box_last=1, go from COLLECT to PENDING on the next cycle.
REQ-022 SHALL, on frame_start in PENDING, copy the staging slots to the active outputs in that same clock edge.
REQ-023 SHALL write 0 to all four edges of every active slot at index >= stage_cnt during the commit.
REQ-024 SHALL, during the commit, set box_count=stage_cnt, set ena=(stage_cnt!=0), clear stage_cnt and overflow_err, and return to COLLECT.
REQ-025 SHALL hold the outputs stable, with new values visible the cycle after the frame_start edge, so the active outputs never change outside a frame_start cycle.
REQ-026 SHALL ignore frame_start in COLLECT for commit purposes, keeping the partial set in staging.
REQ-027 SHALL NOT commit on a frame_start that coincides with an accepted box_last beat; that set commits on the next frame_start.
REQ-028 SHALL keep an 8-bit stale counter that clears on every commit and increments on each non-committing frame_start, saturating at STALE_FRAMES.
REQ-029 SHALL, when the stale counter reaches STALE_FRAMES on a frame_start, zero all active slots, set box_count=0 and set ena=0 on that edge.
REQ-030 SHALL NOT let the stale clear touch the staging slots.
REQ-031 SHALL contain no arithmetic beyond the comparisons, stage_cnt and the stale counter, so outputs are purely registered.

Reset
REQ-032 SHALL, on rst_n=0 at a clock edge, set the state to COLLECT and clear stage_cnt, the stale counter and overflow_err.
REQ-033 SHALL, on the same reset, zero all line_* outputs and set box_count=0 and ena=0.
REQ-034 SHALL, on the same reset, drive box_ready=0 during reset and 1 on the first cycle after release.
REQ-035 SHALL discard any staging content and any in-flight transfer when reset is asserted mid-operation.

Verification
REQ-036 SHALL be verified with: boxes (10,50,20,80) and (100,140,20,80), the second with last, then frame_start -> next cycle slot1=(10,50,20,80), slot2=(100,140,20,80), slots 3-4 all 0, box_count=2, ena=1.
REQ-037 SHALL be verified with: 6 well-formed boxes, the 6th with last -> the first 4 are committed, box_count=4 and overflow_err=1 before frame_start, and overflow_err=0 after the commit.
REQ-038 SHALL be verified with: box (50,50,10,20) with last, then frame_start -> box dropped, box_count=0, ena=0.
REQ-039 SHALL be verified with: box_last accepted on the same cycle as frame_start -> outputs unchanged and box_ready=0; the commit occurs on the following frame_start.
REQ-040 SHALL be verified with: after a 1-box commit and STALE_FRAMES=3, three frame_starts with no set -> on the 3rd, ena=0, box_count=0 and all line_* are 0.
REQ-041 SHALL be verified with: rst_n=0 for one cycle while in PENDING with 3 staged boxes -> all outputs are 0, box_ready=1 after release, and the next frame_start leaves box_count=0.
